pelota: RTL and testbench
=========================

PELOTA -- requirements
Module: pelota

Interface
REQ-001 Parameter TOP, default 30: lowest legal ball_y (top wall row).
REQ-002 Parameter BOTTOM, default 449: bottom wall row; ball_y max = BOTTOM-SIZE+1.
REQ-003 Parameter RIGHT, default 620: right wall column; ball_x max = RIGHT-SIZE+1.
REQ-004 Parameter PADDLE_R, default 20: first column right of the paddle; ball_x min.
REQ-005 Parameter PADDLE_H, default 120: paddle height; paddle spans rows paddle_y .. paddle_y+PADDLE_H-1.
REQ-006 Parameter SIZE, default 8: ball is SIZE x SIZE pixels, anchored at top-left (ball_x, ball_y).
REQ-007 Parameter SPEED, default 2: pixels moved per axis per tick.
REQ-008 Parameter MISS_FRAMES, default 60: ticks held in MISS.
REQ-009 clk  input  1  system clock; all state changes on rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 tick  input  1  one-cycle frame strobe; movement happens only on cycles with tick=1.
REQ-012 start  input  1  serve / restart request, level-sampled.
REQ-013 paddle_y  input  10  paddle top row from the paddle-position block, unsigned.
REQ-014 ball_x  output  10  ball left column, registered.
REQ-015 ball_y  output  10  ball top row, registered.
REQ-016 score  output  8  paddle hits, saturating at 255.
REQ-017 lives  output  2  remaining lives.
REQ-018 hit  output  1  one-cycle pulse on paddle return.
REQ-019 miss  output  1  one-cycle pulse on missed ball.
REQ-020 game_over  output  1  high while in state OVER.

Function
REQ-021 FSM states IDLE, PLAY, MISS, OVER; state register only, all outputs registered.
REQ-022 IDLE: ball held at (316,236), dx=+, dy=+; start=1 -> PLAY next cycle, no movement that cycle even if tick=1.
REQ-023 PLAY, tick=1: nx = ball_x +/- SPEED, ny = ball_y +/- SPEED per direction; both axes evaluated in the same cycle.
REQ-024 Y axis: dy=+ and ny >= BOTTOM-SIZE+1 -> ball_y = BOTTOM-SIZE+1, dy flips; dy=- and ny <= TOP -> ball_y = TOP, dy flips; else ball_y = ny.
REQ-025 X right: dx=+ and nx >= RIGHT-SIZE+1 -> ball_x = RIGHT-SIZE+1, dx flips.
REQ-026 X left: dx=- and nx <= PADDLE_R -> overlap test ball_y+SIZE-1 >= paddle_y AND ball_y <= paddle_y+PADDLE_H-1, using current ball_y.
REQ-027 Overlap true: ball_x = PADDLE_R, dx flips, hit=1 for one cycle, score +1 (hold at 255).
REQ-028 Overlap false: ball_x/ball_y frozen at current values, miss=1 for one cycle, lives -1, -> MISS.
REQ-029 Corner case (Y bounce and paddle hit/miss in same tick): Y rule of REQ-024 still applies; on miss the Y update is discarded.
REQ-030 Left-boundary arithmetic: compare using ball_x <= PADDLE_R+SPEED, so no unsigned underflow at small ball_x.
REQ-031 Arithmetic: internal sums at least 11 bits wide so that ny+SIZE cannot wrap at 10 bits.
REQ-032 PLAY, tick=0: no change.
REQ-033 MISS: counter counts ticks; on the MISS_FRAMES-th tick, ball -> (316,236), dx=+, dy=+, then lives=0 -> OVER, else -> IDLE.
REQ-034 OVER: game_over=1, ball frozen; start=1 -> lives=3, score=0, ball centred, -> IDLE.
REQ-035 start ignored in PLAY and MISS.
REQ-036 hit and miss never asserted in the same cycle.

Reset
REQ-037 reset=1 at any clock edge -> state IDLE, ball (316,236), dx=+, dy=+, score=0, lives=3, hit=0, miss=0, game_over=0, MISS counter=0; reset overrides tick and start.

Verification
REQ-038 reset, then start=1 for 1 cycle, then 1 tick -> ball (318,238), state PLAY.
REQ-039 after start, 103 ticks -> ball (522,442) with dy flipped; tick 104 -> (524,440).
REQ-040 after start, 149 ticks -> ball_x=613 with dx flipped; next tick -> ball_x=611.
REQ-041 paddle_y tracks ball_y-50 during the return -> on arrival ball_x=20, hit pulse 1 cycle, score 0->1, dx becomes +.
REQ-042 paddle_y held at 30, ball arrives with ball_y>=150 -> miss pulse, lives 3->2, ball frozen; 60 ticks later IDLE with ball (316,236); third miss -> OVER, game_over=1.
REQ-043 reset asserted mid-PLAY, coincident with tick=1 -> next cycle IDLE, ball (316,236), score 0, lives 3.

Source files
------------

// File: rtl/pelota_if.sv
// pelota_if -- signal bundle between the pelota ball engine and its
// surroundings (frame timing, paddle-position block, renderer, score display).
//
// Signals:
//   tick      frame strobe, one clk cycle wide
//   start     serve / restart request, level-sampled
//   paddle_y  paddle top row (unsigned, 10 bits)
//   ball_x    ball left column (10 bits)
//   ball_y    ball top row (10 bits)
//   score     paddle hits, saturating at 255
//   lives     remaining lives
//   hit       one-cycle pulse on a paddle return
//   miss      one-cycle pulse on a missed ball
//   game_over high while the game is over
//
// Modports:
//   master  drives the controls and observes the ball/score (bench, top level)
//   slave   the ball engine itself
interface pelota_if;
  logic       tick;
  logic       start;
  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit;
  logic       miss;
  logic       game_over;

  modport master (
    output tick, start, paddle_y,
    input  ball_x, ball_y, score, lives, hit, miss, game_over
  );

  modport slave (
    input  tick, start, paddle_y,
    output ball_x, ball_y, score, lives, hit, miss, game_over
  );
endinterface

// File: rtl/pelota.sv
// pelota -- ball engine for a single-player wall-and-paddle game.
//
// The ball is a SIZE x SIZE square anchored at its top-left corner. On each
// frame tick while playing it moves SPEED pixels on both axes, bouncing off
// the top, bottom and right walls. At the left it is either returned by the
// paddle (score +1) or missed (life -1), after which it rests for
// MISS_FRAMES ticks before being re-centred for the next serve. Losing the
// last life parks the game in OVER until start is pressed.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high reset; overrides tick and start
//   bus    pelota_if.slave: tick/start/paddle_y in,
//          ball_x/ball_y/score/lives/hit/miss/game_over out (all registered)
module pelota #(
  parameter int unsigned TOP         = 30,
  parameter int unsigned BOTTOM      = 449,
  parameter int unsigned RIGHT       = 620,
  parameter int unsigned PADDLE_R    = 20,
  parameter int unsigned PADDLE_H    = 120,
  parameter int unsigned SIZE        = 8,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned MISS_FRAMES = 60
) (
  input logic     clk,
  input logic     reset,
  pelota_if.slave bus
);

  // Limits are kept 11 bits wide so that ball position plus size or step can
  // never wrap when compared against them.
  localparam logic [10:0] Y_MAX_W      = 11'(BOTTOM - SIZE + 1);
  localparam logic [10:0] X_MAX_W      = 11'(RIGHT - SIZE + 1);
  localparam logic [10:0] Y_TOP_GUARD  = 11'(TOP + SPEED);
  localparam logic [10:0] X_LEFT_GUARD = 11'(PADDLE_R + SPEED);
  localparam logic [10:0] STEP_W       = 11'(SPEED);
  localparam logic [10:0] BALL_SPAN    = 11'(SIZE - 1);
  localparam logic [10:0] PAD_SPAN     = 11'(PADDLE_H - 1);

  localparam logic [9:0]  Y_MAX   = 10'(BOTTOM - SIZE + 1);
  localparam logic [9:0]  X_MAX   = 10'(RIGHT - SIZE + 1);
  localparam logic [9:0]  Y_TOP   = 10'(TOP);
  localparam logic [9:0]  X_LEFT  = 10'(PADDLE_R);
  localparam logic [9:0]  STEP    = 10'(SPEED);
  localparam logic [9:0]  HOME_X  = 10'd316;
  localparam logic [9:0]  HOME_Y  = 10'd236;
  localparam logic [1:0]  LIVES_INIT = 2'd3;

  localparam int unsigned    CNT_W    = $clog2(MISS_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    MISS,
    OVER
  } state_t;

  state_t           state;
  logic [9:0]       ball_x;
  logic [9:0]       ball_y;
  logic             dx_pos;
  logic             dy_pos;
  logic [7:0]       score;
  logic [1:0]       lives;
  logic             hit;
  logic             miss;
  logic             game_over;
  logic [CNT_W-1:0] miss_cnt;

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] p_ext;
  logic [10:0] nx_up;
  logic [10:0] ny_up;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        x_flip;
  logic        y_flip;
  logic        left_event;
  logic        overlap;

  assign bus.ball_x    = ball_x;
  assign bus.ball_y    = ball_y;
  assign bus.score     = score;
  assign bus.lives     = lives;
  assign bus.hit       = hit;
  assign bus.miss      = miss;
  assign bus.game_over = game_over;

  // Candidate position for the next tick, evaluated for both axes at once.
  // Downward-going (decreasing) moves are compared as "ball <= limit+SPEED"
  // rather than "ball-SPEED <= limit" so small coordinates never underflow.
  // The left wall only flags an event here; whether it becomes a paddle
  // return or a miss is decided in the sequential block using overlap.
  always_comb begin
    x_ext      = {1'b0, ball_x};
    y_ext      = {1'b0, ball_y};
    p_ext      = {1'b0, bus.paddle_y};
    nx_up      = x_ext + STEP_W;
    ny_up      = y_ext + STEP_W;
    x_next     = ball_x;
    y_next     = ball_y;
    x_flip     = 1'b0;
    y_flip     = 1'b0;
    left_event = 1'b0;

    if (dy_pos) begin
      if (ny_up >= Y_MAX_W) begin
        y_next = Y_MAX;
        y_flip = 1'b1;
      end else begin
        y_next = ny_up[9:0];
      end
    end else begin
      if (y_ext <= Y_TOP_GUARD) begin
        y_next = Y_TOP;
        y_flip = 1'b1;
      end else begin
        y_next = ball_y - STEP;
      end
    end

    if (dx_pos) begin
      if (nx_up >= X_MAX_W) begin
        x_next = X_MAX;
        x_flip = 1'b1;
      end else begin
        x_next = nx_up[9:0];
      end
    end else begin
      if (x_ext <= X_LEFT_GUARD) begin
        x_next     = X_LEFT;
        x_flip     = 1'b1;
        left_event = 1'b1;
      end else begin
        x_next = ball_x - STEP;
      end
    end

    overlap = (y_ext + BALL_SPAN >= p_ext) && (y_ext <= p_ext + PAD_SPAN);
  end

  // Game state machine. Everything visible outside is a register updated
  // here; hit and miss default low so they can only ever be one-cycle
  // pulses, and they come from mutually exclusive branches.
  // A miss freezes the ball where it was, discarding that tick's Y move.
  // Every path back to IDLE re-centres the ball and resets both directions
  // so the next serve always follows the same opening trajectory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ball_x    <= HOME_X;
      ball_y    <= HOME_Y;
      dx_pos    <= 1'b1;
      dy_pos    <= 1'b1;
      score     <= 8'd0;
      lives     <= LIVES_INIT;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= PLAY;
          end
        end

        PLAY: begin
          if (bus.tick) begin
            if (left_event && !overlap) begin
              miss     <= 1'b1;
              lives    <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
              miss_cnt <= '0;
              state    <= MISS;
            end else begin
              ball_x <= x_next;
              ball_y <= y_next;
              if (x_flip) begin
                dx_pos <= ~dx_pos;
              end
              if (y_flip) begin
                dy_pos <= ~dy_pos;
              end
              if (left_event) begin
                hit <= 1'b1;
                if (score != 8'hFF) begin
                  score <= score + 8'd1;
                end
              end
            end
          end
        end

        MISS: begin
          if (bus.tick) begin
            if (miss_cnt == CNT_LAST) begin
              miss_cnt <= '0;
              ball_x   <= HOME_X;
              ball_y   <= HOME_Y;
              dx_pos   <= 1'b1;
              dy_pos   <= 1'b1;
              if (lives == 2'd0) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
        end

        OVER: begin
          if (bus.start) begin
            lives     <= LIVES_INIT;
            score     <= 8'd0;
            ball_x    <= HOME_X;
            ball_y    <= HOME_Y;
            dx_pos    <= 1'b1;
            dy_pos    <= 1'b1;
            game_over <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pelota.sv
// tb_pelota -- directed, self-checking bench for pelota with default
// parameters. Every expected coordinate below is worked out by hand from the
// opening serve at (316,236) moving +2/+2 per tick:
//   tick 103 : bottom bounce at y=442, x=522
//   tick 149 : right bounce at x=613, y=350
//   tick 309 : top bounce at y=30
//   tick 445 : (21,302) heading left; tick 446 reaches the paddle column
module tb_pelota;
  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  pelota_if bus ();

  pelota dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock cycle with the given controls; outputs are stable by #1.
  task automatic applyStimulus(input logic tickVal, input logic startVal);
    bus.tick  = tickVal;
    bus.start = startVal;
    @(posedge clk);
    #1;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
  endtask

  // n frame ticks, each preceded by a quiet cycle; returns right after the
  // last tick so its pulses are still visible.
  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkBall(input string tag, input int expX, input int expY);
    checkOutput({tag, ".x"}, 32'(bus.ball_x), expX);
    checkOutput({tag, ".y"}, 32'(bus.ball_y), expY);
  endtask

  task automatic checkStats(input string tag, input int expScore, input int expLives);
    checkOutput({tag, ".score"}, 32'(bus.score), expScore);
    checkOutput({tag, ".lives"}, 32'(bus.lives), expLives);
  endtask

  task automatic checkFlags(input string tag, input logic expHit,
                            input logic expMiss, input logic expOver);
    checkOutput({tag, ".hit"}, 32'(bus.hit), 32'(expHit));
    checkOutput({tag, ".miss"}, 32'(bus.miss), 32'(expMiss));
    checkOutput({tag, ".game_over"}, 32'(bus.game_over), 32'(expOver));
  endtask

  initial begin
    assertCount  = 0;
    failCount    = 0;
    reset        = 1'b1;
    bus.tick     = 1'b0;
    bus.start    = 1'b0;
    bus.paddle_y = 10'd252;

    // Reset wins over tick and start.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkBall("reset", 316, 236);
    checkStats("reset", 0, 3);
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Start with a coincident tick: enters PLAY, no movement yet.
    applyStimulus(1'b1, 1'b1);
    checkBall("serve", 316, 236);
    doTicks(1);
    checkBall("tick1", 318, 238);

    // Idle cycles and a stray start while playing change nothing.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkBall("noTick", 318, 238);

    // Bottom wall bounce.
    doTicks(102);
    checkBall("tick103", 522, 442);
    doTicks(1);
    checkBall("tick104", 524, 440);

    // Right wall bounce.
    doTicks(45);
    checkBall("tick149", 613, 350);
    doTicks(1);
    checkBall("tick150", 611, 348);

    // Paddle return with paddle at ball_y-50.
    doTicks(295);
    checkBall("tick445", 21, 302);
    checkFlags("tick445", 1'b0, 1'b0, 1'b0);
    doTicks(1);
    checkBall("hit", 20, 304);
    checkFlags("hit", 1'b1, 1'b0, 1'b0);
    checkStats("hit", 1, 3);
    applyStimulus(1'b0, 1'b0);
    checkFlags("hitPulse", 1'b0, 1'b0, 1'b0);
    doTicks(1);
    checkBall("afterHit", 22, 306);

    // Reset mid-play, coincident with a tick.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    reset = 1'b0;
    checkBall("midReset", 316, 236);
    checkStats("midReset", 0, 3);

    // First miss: paddle parked at the top.
    bus.paddle_y = 10'd30;
    applyStimulus(1'b0, 1'b1);
    doTicks(446);
    checkBall("miss1", 21, 302);
    checkFlags("miss1", 1'b0, 1'b1, 1'b0);
    checkStats("miss1", 0, 2);
    applyStimulus(1'b0, 1'b0);
    checkFlags("miss1Pulse", 1'b0, 1'b0, 1'b0);

    // Ball stays frozen through the rest period; start is ignored there.
    doTicks(10);
    applyStimulus(1'b0, 1'b1);
    doTicks(49);
    checkBall("missHold", 21, 302);
    checkStats("missHold", 0, 2);
    doTicks(1);
    checkBall("respawn1", 316, 236);
    checkFlags("respawn1", 1'b0, 1'b0, 1'b0);

    // IDLE holds the ball without start.
    doTicks(3);
    checkBall("idleHold", 316, 236);

    // Second miss.
    applyStimulus(1'b0, 1'b1);
    doTicks(446);
    checkStats("miss2", 0, 1);
    checkFlags("miss2", 1'b0, 1'b1, 1'b0);
    doTicks(60);
    checkBall("respawn2", 316, 236);

    // Third miss leads to OVER.
    applyStimulus(1'b0, 1'b1);
    doTicks(446);
    checkStats("miss3", 0, 0);
    checkFlags("miss3", 1'b0, 1'b1, 1'b0);
    doTicks(59);
    checkFlags("miss3Wait", 1'b0, 1'b0, 1'b0);
    doTicks(1);
    checkFlags("over", 1'b0, 1'b0, 1'b1);
    checkBall("over", 316, 236);
    doTicks(3);
    checkFlags("overHold", 1'b0, 1'b0, 1'b1);

    // Restart from OVER, then a fresh serve.
    applyStimulus(1'b0, 1'b1);
    checkFlags("restart", 1'b0, 1'b0, 1'b0);
    checkStats("restart", 0, 3);
    applyStimulus(1'b0, 1'b1);
    doTicks(1);
    checkBall("reserve", 318, 238);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
